load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage directly downstream of the execution ALU. It takes the ALU result (effective address or pass-through result), the store data and the memory-op controls. It then runs a request/acknowledge transaction on the data-memory port, doing byte-lane steering, load sign/zero extension, misalignment checks and an ack timeout. Results go to write-back through a one-deep registered output, and the block stalls upstream while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, max cycles mem_req may wait for mem_ack before abort (>=2)
TCNT_W, 5, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  upstream presents a valid instruction this cycle
alu_result  in  32  effective address (mem op) or result to pass through
store_data  in  32  rt value for stores
mem_read  in  1  load
mem_write  in  1  store (mem_read and mem_write never both 1; if so, treat as load)
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
mem_unsigned  in  1  zero-extend loads (LBU/LHU)
wb_reg_in  in  5  destination register
reg_write_in  in  1  instruction writes a register
stall  out  1  upstream must hold its outputs
mem_req  out  1  data-memory request
mem_we  out  1  write enable
mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
mem_wdata  out  32  lane-replicated store data
mem_ack  in  1  memory completes request (rdata valid same cycle)
mem_rdata  in  32  read data
wb_valid  out  1  write-back entry valid
wb_data  out  32  load data or passed-through alu_result
wb_reg  out  5  destination register
wb_reg_write  out  1  write-back enable
exc_misalign  out  1  one-cycle pulse: misaligned access rejected
exc_buserr  out  1  one-cycle pulse: ack timeout
exc_addr  out  32  faulting byte address, held until next exception

Behaviour:
- Reset: state IDLE; mem_req, mem_we, wb_valid, wb_reg_write, exc_misalign, exc_buserr = 0. mem_addr, mem_be, mem_wdata, wb_data, wb_reg, exc_addr = 0. Timeout counter = 0. Reset mid-transaction aborts: mem_req low after the reset edge, no wb_valid, no exception.
- States: IDLE, BUSY.
- IDLE, ex_valid=1, no mem op: pass-through. Next edge: wb_valid=1, wb_data=alu_result, wb_reg/wb_reg_write from inputs. Latency 1, stall=0.
- IDLE, ex_valid=0: wb_valid=0 next edge.
- IDLE, mem op, misaligned (half with addr[0]=1; word with addr[1:0]!=0): no request. Next edge: wb_valid=1, wb_reg_write=0, exc_misalign=1, exc_addr=alu_result. stall=0.
- IDLE, mem op, aligned: stall=1 combinationally this cycle. Next edge: BUSY, mem_req=1, mem_we=mem_write, with mem_addr/mem_be/mem_wdata registered. Latch wb_reg_in, reg_write_in (forced 0 for stores), size, unsigned, addr[1:0]. wb_valid=0.
- BUSY: mem_req and all request fields held stable. stall = 1 while BUSY and mem_ack=0; stall=0 in the ack cycle, so upstream advances that cycle. Ack edge: state IDLE, mem_req=0, wb_valid=1, wb_data=formatted load (stores: 0), wb_reg_write=latched value. The new ex input in the ack cycle is not accepted; it is accepted the following cycle.
- Timeout: counter clears on entering BUSY and increments each BUSY cycle without ack. If it reaches TIMEOUT_CYCLES-1 with no ack, next edge: IDLE, mem_req=0, exc_buserr=1, exc_addr=latched address, wb_valid=1, wb_reg_write=0. If ack arrives in that same cycle, ack wins and there is no exception.
- mem_ack while IDLE: ignored.
- Store lanes: byte: be=0001<<addr[1:0], wdata={4{sd[7:0]}}. Half: be=0011 (addr[1]=0) or 1100, wdata={2{sd[15:0]}}. Word: be=1111, wdata=sd. Loads: be=1111.
- Load format: select lane by latched addr[1:0]/addr[1], then sign-extend, or zero-extend if unsigned. Word: rdata unchanged.
- Exception pulses last exactly one cycle.

Decomposition:
- Shared package: mem_size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings, lane-select helpers.
- One sub-module, lsu_lane_format: combinational store lane steering/BE generation plus load extract/extend. Shared with any future cache block.

Test Plan:
- Pass-through: ex_valid=1, alu_result=0x0000_1234, reg_write_in=1, wb_reg_in=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_reg=5, stall never high.
- Store byte: addr=0x103, sd=0xAABBCCDD, ack after 3 cycles -> mem_be=1000, mem_wdata=0xDDDDDDDD, mem_addr=0x100, stall high 3 cycles then low in ack cycle, wb_reg_write=0.
- Load byte signed/unsigned: addr=0x102, rdata=0x0080_0000, ack same cycle as req -> wb_data=0xFFFFFF80 (LB), 0x00000080 (LBU).
- Load half addr=0x202, rdata=0x8001_7FFF -> wb_data=0xFFFF8001; word load addr=0x201 -> no mem_req, exc_misalign=1, exc_addr=0x201.
- Timeout: TIMEOUT_CYCLES=16, no ack -> mem_req high 16 cycles, then exc_buserr=1 pulse, state IDLE. Late ack afterwards is ignored.
- Reset asserted in 2nd BUSY cycle -> after edge mem_req=0, wb_valid=0, no exceptions; next pass-through completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and lane helpers for the load/store unit and its lane formatter.
package load_store_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } lsu_state_t;

    function automatic logic [3:0] byte_be(input logic [1:0] lo);
        return 4'b0001 << lo;
    endfunction

    function automatic logic [3:0] half_be(input logic hi);
        return hi ? 4'b1100 : 4'b0011;
    endfunction

    // Size 11 behaves as a word access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Combinational store lane steering / byte enables and load lane extract / extension.
module lsu_lane_format
    import load_store_unit_pkg::*;
(
    input  logic        st_write,
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lo,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign ld_byte = rdata[{ld_lo, 3'b000} +: 8];
    assign ld_half = ld_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_size)
            SZ_BYTE: begin
                wdata = {4{st_data[7:0]}};
                if (st_write) be = byte_be(st_lo);
            end
            SZ_HALF: begin
                wdata = {2{st_data[15:0]}};
                if (st_write) be = half_be(st_lo[1]);
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_data = rdata;
        case (ld_size)
            SZ_BYTE: ld_data = ld_unsigned ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = ld_unsigned ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/ack data-memory transaction, misalign and timeout checks,
// one-deep registered write-back output.
//   state   | meaning
//   ST_IDLE | accepting ex inputs; pass-through, misalign reject, or issue request
//   ST_BUSY | request outstanding; waiting for mem_ack or timeout
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TCNT_W         = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [4:0]  wb_reg_in,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_reg_write,
    output logic        exc_misalign,
    output logic        exc_buserr,
    output logic [31:0] exc_addr
);

    lsu_state_t        state, nxt_state;
    logic [TCNT_W-1:0] tcnt, nxt_tcnt;
    logic [1:0]        lat_size, nxt_lat_size;
    logic [1:0]        lat_lo, nxt_lat_lo;
    logic              lat_uns, nxt_lat_uns;
    logic [4:0]        lat_dst, nxt_lat_dst;
    logic              lat_rw, nxt_lat_rw;

    logic        nxt_mem_req, nxt_mem_we;
    logic [31:0] nxt_mem_addr, nxt_mem_wdata;
    logic [3:0]  nxt_mem_be;
    logic        nxt_wb_valid, nxt_wb_reg_write;
    logic [31:0] nxt_wb_data;
    logic [4:0]  nxt_wb_reg;
    logic        nxt_exc_misalign, nxt_exc_buserr;
    logic [31:0] nxt_exc_addr;

    logic        is_load, is_store, mem_op, misal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    // A read+write request is treated as a load.
    assign is_load  = mem_read;
    assign is_store = mem_write & ~mem_read;
    assign mem_op   = is_load | is_store;
    assign misal    = misaligned(mem_size, alu_result[1:0]);

    lsu_lane_format u_lane (
        .st_write    (is_store),
        .st_size     (mem_size),
        .st_lo       (alu_result[1:0]),
        .st_data     (store_data),
        .be          (st_be),
        .wdata       (st_wdata),
        .ld_size     (lat_size),
        .ld_lo       (lat_lo),
        .ld_unsigned (lat_uns),
        .rdata       (mem_rdata),
        .ld_data     (ld_data)
    );

    always_comb begin
        nxt_state        = state;
        nxt_tcnt         = tcnt;
        nxt_lat_size     = lat_size;
        nxt_lat_lo       = lat_lo;
        nxt_lat_uns      = lat_uns;
        nxt_lat_dst      = lat_dst;
        nxt_lat_rw       = lat_rw;
        nxt_mem_req      = mem_req;
        nxt_mem_we       = mem_we;
        nxt_mem_addr     = mem_addr;
        nxt_mem_be       = mem_be;
        nxt_mem_wdata    = mem_wdata;
        nxt_wb_valid     = 1'b0;
        nxt_wb_reg_write = 1'b0;
        nxt_wb_data      = wb_data;
        nxt_wb_reg       = wb_reg;
        nxt_exc_misalign = 1'b0;
        nxt_exc_buserr   = 1'b0;
        nxt_exc_addr     = exc_addr;
        stall            = 1'b0;

        case (state)
            ST_IDLE: begin
                if (ex_valid) begin
                    nxt_wb_reg = wb_reg_in;
                    if (!mem_op) begin
                        nxt_wb_valid     = 1'b1;
                        nxt_wb_data      = alu_result;
                        nxt_wb_reg_write = reg_write_in;
                    end else if (misal) begin
                        nxt_wb_valid     = 1'b1;
                        nxt_wb_data      = 32'b0;
                        nxt_exc_misalign = 1'b1;
                        nxt_exc_addr     = alu_result;
                    end else begin
                        stall         = 1'b1;
                        nxt_state     = ST_BUSY;
                        nxt_tcnt      = '0;
                        nxt_mem_req   = 1'b1;
                        nxt_mem_we    = is_store;
                        nxt_mem_addr  = {alu_result[31:2], 2'b00};
                        nxt_mem_be    = st_be;
                        nxt_mem_wdata = st_wdata;
                        nxt_lat_size  = mem_size;
                        nxt_lat_lo    = alu_result[1:0];
                        nxt_lat_uns   = mem_unsigned;
                        nxt_lat_dst   = wb_reg_in;
                        nxt_lat_rw    = reg_write_in & ~is_store;
                        nxt_wb_reg    = wb_reg;
                    end
                end
            end
            ST_BUSY: begin
                stall = ~mem_ack;
                // Ack in the final timeout cycle still completes normally.
                if (mem_ack) begin
                    nxt_state        = ST_IDLE;
                    nxt_mem_req      = 1'b0;
                    nxt_mem_we       = 1'b0;
                    nxt_wb_valid     = 1'b1;
                    nxt_wb_data      = mem_we ? 32'b0 : ld_data;
                    nxt_wb_reg       = lat_dst;
                    nxt_wb_reg_write = lat_rw;
                end else if (tcnt == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    nxt_state      = ST_IDLE;
                    nxt_mem_req    = 1'b0;
                    nxt_mem_we     = 1'b0;
                    nxt_wb_valid   = 1'b1;
                    nxt_wb_data    = 32'b0;
                    nxt_wb_reg     = lat_dst;
                    nxt_exc_buserr = 1'b1;
                    nxt_exc_addr   = {mem_addr[31:2], lat_lo};
                end else begin
                    nxt_tcnt = tcnt + TCNT_W'(1);
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            tcnt         <= '0;
            lat_size     <= 2'b00;
            lat_lo       <= 2'b00;
            lat_uns      <= 1'b0;
            lat_dst      <= 5'b0;
            lat_rw       <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'b0;
            mem_be       <= 4'b0;
            mem_wdata    <= 32'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'b0;
            wb_reg       <= 5'b0;
            exc_misalign <= 1'b0;
            exc_buserr   <= 1'b0;
            exc_addr     <= 32'b0;
        end else begin
            state        <= nxt_state;
            tcnt         <= nxt_tcnt;
            lat_size     <= nxt_lat_size;
            lat_lo       <= nxt_lat_lo;
            lat_uns      <= nxt_lat_uns;
            lat_dst      <= nxt_lat_dst;
            lat_rw       <= nxt_lat_rw;
            mem_req      <= nxt_mem_req;
            mem_we       <= nxt_mem_we;
            mem_addr     <= nxt_mem_addr;
            mem_be       <= nxt_mem_be;
            mem_wdata    <= nxt_mem_wdata;
            wb_valid     <= nxt_wb_valid;
            wb_reg_write <= nxt_wb_reg_write;
            wb_data      <= nxt_wb_data;
            wb_reg       <= nxt_wb_reg;
            exc_misalign <= nxt_exc_misalign;
            exc_buserr   <= nxt_exc_buserr;
            exc_addr     <= nxt_exc_addr;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table driven per transaction,
// write-back results checked through an expected-result queue.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [4:0]  wb_reg_in;
    logic        reg_write_in;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_reg_write, exc_misalign, exc_buserr;
    logic [31:0] exc_addr;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(16), .TCNT_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .alu_result(alu_result),
        .store_data(store_data), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .wb_reg_in(wb_reg_in),
        .reg_write_in(reg_write_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_reg(wb_reg),
        .wb_reg_write(wb_reg_write), .exc_misalign(exc_misalign), .exc_buserr(exc_buserr),
        .exc_addr(exc_addr)
    );

    typedef struct {
        logic [31:0] addr, sd, rdata;
        logic        rd, wr;
        logic [1:0]  size;
        logic        uns;
        logic [4:0]  dst;
        logic        rw;
        int          delay;
        logic        to;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_wb;
        logic        e_rw, e_mis, e_bus;
        logic [31:0] e_exc;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  dst;
        logic        rw, mis, bus;
        logic [31:0] exc;
    } wb_t;

    int   total = 0;
    int   bad = 0;
    logic started = 1'b0;
    wb_t  exp_q[$];
    wb_t  mon_w;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, sd, rdata, input logic rd, wr,
                                input logic [1:0] size, input logic uns, input logic [4:0] dst,
                                input logic rw, input int delay, input logic to,
                                input logic e_req, e_we, input logic [31:0] e_addr,
                                input logic [3:0] e_be, input logic [31:0] e_wdata, e_wb,
                                input logic e_rw, e_mis, e_bus, input logic [31:0] e_exc);
        vec_t v;
        v.addr = addr; v.sd = sd; v.rdata = rdata; v.rd = rd; v.wr = wr; v.size = size;
        v.uns = uns; v.dst = dst; v.rw = rw; v.delay = delay; v.to = to;
        v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_be = e_be;
        v.e_wdata = e_wdata; v.e_wb = e_wb; v.e_rw = e_rw; v.e_mis = e_mis;
        v.e_bus = e_bus; v.e_exc = e_exc;
        return v;
    endfunction

    // Write-back monitor: every wb_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (started && !rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wb actual=wb_valid=1 data=%h required=no write-back", wb_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("wb_reg_write", 32'(wb_reg_write), 32'(mon_w.rw));
                    chk("exc_misalign", 32'(exc_misalign), 32'(mon_w.mis));
                    chk("exc_buserr", 32'(exc_buserr), 32'(mon_w.bus));
                    if (mon_w.mis || mon_w.bus) begin
                        chk("exc_addr", exc_addr, mon_w.exc);
                    end else begin
                        chk("wb_data", wb_data, mon_w.data);
                        chk("wb_reg", 32'(wb_reg), 32'(mon_w.dst));
                    end
                end
            end else begin
                chk("exc_idle", 32'({exc_misalign, exc_buserr}), 32'd0);
            end
        end
    end

    task automatic drive_ex(input vec_t v);
        ex_valid     = 1'b1;
        alu_result   = v.addr;
        store_data   = v.sd;
        mem_read     = v.rd;
        mem_write    = v.wr;
        mem_size     = v.size;
        mem_unsigned = v.uns;
        wb_reg_in    = v.dst;
        reg_write_in = v.rw;
    endtask

    task automatic run_vec(input vec_t v);
        wb_t w;
        @(negedge clk);
        drive_ex(v);
        w.data = v.e_wb; w.dst = v.dst; w.rw = v.e_rw; w.mis = v.e_mis;
        w.bus = v.e_bus; w.exc = v.e_exc;
        exp_q.push_back(w);
        #1 chk("stall_issue", 32'(stall), 32'(v.e_req));
        @(negedge clk);
        chk("mem_req", 32'(mem_req), 32'(v.e_req));
        if (v.e_req) begin
            chk("mem_addr", mem_addr, v.e_addr);
            chk("mem_be", 32'(mem_be), 32'(v.e_be));
            chk("mem_we", 32'(mem_we), 32'(v.e_we));
            if (v.e_we) chk("mem_wdata", mem_wdata, v.e_wdata);
            for (int k = 0; k < v.delay; k++) begin
                chk("stall_busy", 32'(stall), 32'd1);
                chk("req_held", 32'(mem_req), 32'd1);
                chk("addr_held", mem_addr, v.e_addr);
                @(negedge clk);
            end
            if (v.to) begin
                ex_valid = 1'b0;
                chk("req_after_timeout", 32'(mem_req), 32'd0);
                mem_ack   = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
                @(negedge clk);
                mem_ack = 1'b0;
                chk("req_late_ack", 32'(mem_req), 32'd0);
            end else begin
                mem_ack   = 1'b1;
                mem_rdata = v.rdata;
                #1 chk("stall_ack", 32'(stall), 32'd0);
                @(negedge clk);
                mem_ack  = 1'b0;
                ex_valid = 1'b0;
                chk("req_after_ack", 32'(mem_req), 32'd0);
            end
        end
        ex_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; alu_result = '0; store_data = '0; mem_read = 1'b0;
        mem_write = 1'b0; mem_size = 2'b00; mem_unsigned = 1'b0; wb_reg_in = '0;
        reg_write_in = 1'b0; mem_ack = 1'b0; mem_rdata = '0;

        //        addr          sd            rdata         rd wr sz    u  dst rw dly to req we e_addr        be       e_wdata       e_wb          rw mis bus e_exc
        vecs.push_back(mk(32'h0000_1234, 32'h0,        32'h0,        0, 0, 2'b10, 0, 5,  1, 0, 0, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0000_1234, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0103, 32'hAABBCCDD, 32'h0,        0, 1, 2'b00, 0, 7,  1, 2, 0, 1, 1, 32'h0000_0100, 4'b1000, 32'hDDDDDDDD, 32'h0,         0, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        32'h0080_0000, 1, 0, 2'b00, 0, 3,  1, 0, 0, 1, 0, 32'h0000_0100, 4'hF,    32'h0,        32'hFFFF_FF80, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0102, 32'h0,        32'h0080_0000, 1, 0, 2'b00, 1, 4,  1, 0, 0, 1, 0, 32'h0000_0100, 4'hF,    32'h0,        32'h0000_0080, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0202, 32'h0,        32'h8001_7FFF, 1, 0, 2'b01, 0, 9,  1, 1, 0, 1, 0, 32'h0000_0200, 4'hF,    32'h0,        32'hFFFF_8001, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0200, 32'h0,        32'h8001_7FFF, 1, 0, 2'b01, 1, 10, 1, 0, 0, 1, 0, 32'h0000_0200, 4'hF,    32'h0,        32'h0000_7FFF, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0201, 32'h0,        32'h0,        1, 0, 2'b10, 0, 11, 1, 0, 0, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0,         0, 1, 0, 32'h0000_0201));
        vecs.push_back(mk(32'h0000_0206, 32'h11223344, 32'h0,        0, 1, 2'b01, 0, 12, 0, 1, 0, 1, 1, 32'h0000_0204, 4'b1100, 32'h33443344, 32'h0,         0, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0300, 32'hCAFEF00D, 32'h0,        0, 1, 2'b10, 0, 13, 1, 0, 0, 1, 1, 32'h0000_0300, 4'hF,    32'hCAFEF00D, 32'h0,         0, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0400, 32'h0,        32'h1234_5678, 1, 0, 2'b11, 0, 14, 1, 4, 0, 1, 0, 32'h0000_0400, 4'hF,    32'h0,        32'h1234_5678, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0101, 32'h0,        32'h0,        0, 1, 2'b01, 0, 15, 1, 0, 0, 0, 0, 32'h0,        4'h0,    32'h0,        32'h0,         0, 1, 0, 32'h0000_0101));
        vecs.push_back(mk(32'h0000_0500, 32'h5555_5555, 32'hDEAD_BEEF, 1, 1, 2'b10, 0, 16, 1, 1, 0, 1, 0, 32'h0000_0500, 4'hF,    32'h0,        32'hDEAD_BEEF, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0600, 32'h0,        32'h0000_007F, 1, 0, 2'b00, 0, 17, 1, 0, 0, 1, 0, 32'h0000_0600, 4'hF,    32'h0,        32'h0000_007F, 1, 0, 0, 32'h0));
        vecs.push_back(mk(32'h0000_0702, 32'h0,        32'h0,        1, 0, 2'b01, 0, 18, 1, 16, 1, 1, 0, 32'h0000_0700, 4'hF,   32'h0,        32'h0,         0, 0, 1, 32'h0000_0702));

        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_exc", 32'({exc_misalign, exc_buserr, wb_reg_write, mem_we}), 32'd0);
        chk("rst_exc_addr", exc_addr, 32'd0);
        rst = 1'b0;
        started = 1'b1;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the second BUSY cycle aborts without write-back or exception.
        @(negedge clk);
        drive_ex(vecs[5]);
        @(negedge clk);
        chk("rstmid_req_busy", 32'(mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_wb_valid", 32'(wb_valid), 32'd0);
        chk("rstmid_exc", 32'({exc_misalign, exc_buserr}), 32'd0);
        rst = 1'b0;
        ex_valid = 1'b0;
        run_vec(vecs[0]);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
